traffic_test_sequencer: RTL and testbench
=========================================

# traffic_test_sequencer

Autonomous Avalon-MM master that runs one complete loopback traffic test through the traffic controller's CSR port. It arms the monitor, programs and starts the generator, polls the monitor until done, error or timeout, then reads back the good-packet count and reports a verdict. It sits between the test host (or a boot FSM) and the controller's `avl_mm_*` slave port, so a test needs no host-side register sequencing.

## Interface
- `GEN_BASE`, 24'h000000, byte base address of the generator CSR block.
- `MON_BASE`, 24'h040000, byte base address of the monitor CSR block (word address [23:16] = 1).
- `GEN_PKTNUM_OFS`, 24'h000000, generator packet-count register byte offset.
- `GEN_START_OFS`, 24'h000004, generator start register byte offset; bit 0 is write-1-to-start.
- `MON_CTRL_OFS`, 24'h000004, monitor control register byte offset; bit 0 is write-1-to-arm/clear.
- `MON_STAT_OFS`, 24'h000008, monitor status register byte offset.
- `MON_GOOD_OFS`, 24'h00000C, monitor good-packet counter byte offset.
- `DONE_BIT`, 2, status bit meaning monitor done.
- `ERR_BIT`, 3, status bit meaning monitor error.
- `POLL_GAP`, 16, idle cycles between status polls (≥1).
- `TIMEOUT_CYCLES`, 1000000, cycles allowed from generator start to monitor done.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  single-cycle request; accepted only in IDLE or DONE.
- `pkt_count`  in  32  packets to send; sampled when `start` is accepted.
- `busy`  out  1  high from accepted `start` until DONE is entered.
- `done`  out  1  sticky level in DONE; cleared when the next `start` is accepted.
- `pass`  out  1  verdict; valid while `done`=1.
- `fail_code`  out  2  0 = ok, 1 = timeout, 2 = monitor error, 3 = count mismatch.
- `rx_good_count`  out  32  last value read from `MON_GOOD_OFS`.
- `m_address`  out  24  byte address.
- `m_read`  out  1  read strobe.
- `m_write`  out  1  write strobe.
- `m_writedata`  out  32  write data.
- `m_readdata`  in  32  read data; valid in the cycle `m_read` is high and `m_waitrequest` is low.
- `m_waitrequest`  in  1  slave stall.

## Operation
- States: IDLE, ARM_MON, WR_PKTNUM, WR_START, GAP, RD_STAT, RD_GOOD, DONE.
- IDLE/DONE with `start`=1:
  - Latch `pkt_count`; clear `done`, `pass`, `fail_code`.
  - If `pkt_count`==0, go directly to DONE with `pass`=1 and issue no bus access.
  - Otherwise go to ARM_MON.
- ARM_MON: write 32'h1 to `MON_BASE+MON_CTRL_OFS`.
- WR_PKTNUM: write the latched count to `GEN_BASE+GEN_PKTNUM_OFS`.
- WR_START: write 32'h1 to `GEN_BASE+GEN_START_OFS`. On acceptance, clear the timeout counter and go to GAP.
- GAP: count `POLL_GAP` cycles, then go to RD_STAT.
- RD_STAT: read `MON_BASE+MON_STAT_OFS`. On acceptance, priority order:
  - `ERR_BIT` set → DONE with code 2.
  - `DONE_BIT` set → RD_GOOD.
  - Otherwise → GAP.
- RD_GOOD: read `MON_BASE+MON_GOOD_OFS` into `rx_good_count`. Then go to DONE:
  - `pass`=1 and code 0 if the value equals the latched count.
  - Code 3 otherwise.
- Timeout:
  - The counter increments every cycle in GAP and RD_STAT and saturates.
  - When it reaches `TIMEOUT_CYCLES` in GAP, go to DONE with code 1.
  - In RD_STAT, the in-flight read completes first. A status showing done or error takes precedence over the timeout.
- `pass` = (`fail_code`==0) whenever `done`=1. `rx_good_count` holds its value until the next RD_GOOD.
- `start` while `busy` is ignored; there is no queuing.

## Timing
- All outputs are registered. Reset value is 0 for every output, counter and latch; the state resets to IDLE.
- Bus rules:
  - At most one of `m_read`/`m_write` is high.
  - Address, strobes and write data are held stable while `m_waitrequest`=1.
  - A transfer completes in the cycle the strobe is high and `m_waitrequest`=0. The strobe drops on the next edge; the next transfer's strobe may assert on that edge with no idle cycle.
- With zero wait states:
  - `start` at edge N → ARM_MON write visible from N+1.
  - The WR_START write completes at N+3.
  - The first RD_STAT is issued at N+4+`POLL_GAP`.
- `done`, `pass`, `fail_code` and the `busy` falls all update on the same edge that enters DONE.
- Reset asserted mid-transfer: strobes drop asynchronously and the in-flight access is abandoned. The slave must tolerate this.
- Timeout width is ≥ clog2(`TIMEOUT_CYCLES`+1). `POLL_GAP` counter width is ≥ clog2(`POLL_GAP`+1).

## Test plan
- Good run:
  - Stimulus: `pkt_count`=100, zero-wait slave. Status returns `DONE_BIT` on the 5th poll; good count = 100.
  - Required: writes to 0x040004, 0x000000 (data 100) and 0x000004 in that order; 5 reads of 0x040008; 1 read of 0x04000C; then `done`=1, `pass`=1, `fail_code`=0, `rx_good_count`=100.
- Stalls:
  - Stimulus: same as good run, with `m_waitrequest` high for 3 cycles on every access.
  - Required: address, strobe and data stable during each stall; identical transaction list and verdict.
- Monitor error:
  - Stimulus: status read returns `ERR_BIT` and `DONE_BIT` both set.
  - Required: no read of 0x04000C; `fail_code`=2, `pass`=0.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=200, `POLL_GAP`=16, status never done.
  - Required: `done`=1 with `fail_code`=1 within 200+`POLL_GAP`+2 cycles of WR_START completion.
- Mismatch:
  - Stimulus: good count read returns 99 for `pkt_count`=100.
  - Required: `fail_code`=3, `pass`=0, `rx_good_count`=99.
- Edge cases:
  - `pkt_count`=0 → `done`=1 and `pass`=1 one cycle after `start`, with no bus activity.
  - `start` pulsed while busy → ignored.
  - `reset` pulsed during a stalled RD_STAT → all outputs 0 immediately; a following `start` runs the full sequence from ARM_MON.

Source files
------------

// File: rtl/traffic_test_sequencer.sv
// traffic_test_sequencer: Avalon-MM master that runs one loopback traffic test.
// Sequence: arm monitor, program generator count, start generator, poll monitor
// status until done, error or timeout, then read the good count and report.
module traffic_test_sequencer #(
    parameter logic [23:0] GEN_BASE       = 24'h000000,
    parameter logic [23:0] MON_BASE       = 24'h040000,
    parameter logic [23:0] GEN_PKTNUM_OFS = 24'h000000,
    parameter logic [23:0] GEN_START_OFS  = 24'h000004,
    parameter logic [23:0] MON_CTRL_OFS   = 24'h000004,
    parameter logic [23:0] MON_STAT_OFS   = 24'h000008,
    parameter logic [23:0] MON_GOOD_OFS   = 24'h00000C,
    parameter int unsigned DONE_BIT       = 2,
    parameter int unsigned ERR_BIT        = 3,
    parameter int unsigned POLL_GAP       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pkt_count,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [31:0] rx_good_count,
    output logic [23:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(POLL_GAP + 1);
    localparam logic [TW-1:0] TMO_LIM  = TW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

    localparam logic [1:0] FC_OK       = 2'd0;
    localparam logic [1:0] FC_TIMEOUT  = 2'd1;
    localparam logic [1:0] FC_MON_ERR  = 2'd2;
    localparam logic [1:0] FC_MISMATCH = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM_MON, S_WR_PKTNUM, S_WR_START, S_GAP, S_RD_STAT, S_RD_GOOD, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [1:0]    fc_q, fc_d;
    logic [31:0]   rx_q, rx_d;
    logic [23:0]   addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          xfer_ok;

    // Current bus access completes at the next edge.
    assign xfer_ok = (rd_q | wr_q) & ~m_waitrequest;

    // Next-state, bus and verdict computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fc_d    = fc_q;
        rx_d    = rx_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cnt_d  = pkt_count;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    fc_d   = FC_OK;
                    if (pkt_count == 32'd0) begin
                        // Nothing to send: trivially passes with no bus traffic.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_ARM_MON;
                        busy_d  = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = MON_BASE + MON_CTRL_OFS;
                        wdata_d = 32'h1;
                    end
                end
            end
            S_ARM_MON: begin
                if (xfer_ok) begin
                    state_d = S_WR_PKTNUM;
                    addr_d  = GEN_BASE + GEN_PKTNUM_OFS;
                    wdata_d = cnt_q;
                end
            end
            S_WR_PKTNUM: begin
                if (xfer_ok) begin
                    state_d = S_WR_START;
                    addr_d  = GEN_BASE + GEN_START_OFS;
                    wdata_d = 32'h1;
                end
            end
            S_WR_START: begin
                if (xfer_ok) begin
                    state_d = S_GAP;
                    wr_d    = 1'b0;
                    wdata_d = 32'h0;
                    tmo_d   = '0;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                if (tmo_q >= TMO_LIM) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    fc_d    = FC_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = S_RD_STAT;
                        rd_d    = 1'b1;
                        addr_d  = MON_BASE + MON_STAT_OFS;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            S_RD_STAT: begin
                // Timeout keeps counting but only GAP acts on it, so a late
                // done/error status still wins over the timeout.
                if (tmo_q < TMO_LIM) tmo_d = tmo_q + 1'b1;
                if (xfer_ok) begin
                    if (m_readdata[ERR_BIT]) begin
                        state_d = S_DONE;
                        rd_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b0;
                        fc_d    = FC_MON_ERR;
                    end else if (m_readdata[DONE_BIT]) begin
                        state_d = S_RD_GOOD;
                        addr_d  = MON_BASE + MON_GOOD_OFS;
                    end else begin
                        state_d = S_GAP;
                        rd_d    = 1'b0;
                        gap_d   = '0;
                    end
                end
            end
            S_RD_GOOD: begin
                if (xfer_ok) begin
                    state_d = S_DONE;
                    rd_d    = 1'b0;
                    rx_d    = m_readdata;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (m_readdata == cnt_q);
                    fc_d    = (m_readdata == cnt_q) ? FC_OK : FC_MISMATCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fc_q    <= '0;
            rx_q    <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fc_q    <= fc_d;
            rx_q    <= rx_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_code     = fc_q;
    assign rx_good_count = rx_q;
    assign m_address     = addr_q;
    assign m_read        = rd_q;
    assign m_write       = wr_q;
    assign m_writedata   = wdata_q;

endmodule

// File: tb/tb_traffic_test_sequencer.sv
// Bench for traffic_test_sequencer: scripted slave, expected-transaction and
// verdict scoreboards, and a monitor that checks every completed access.
module tb_traffic_test_sequencer;

    localparam int unsigned GAP = 16;
    localparam int unsigned TMO = 200;
    localparam logic [23:0] A_CTRL  = 24'h040004;
    localparam logic [23:0] A_PKT   = 24'h000000;
    localparam logic [23:0] A_START = 24'h000004;
    localparam logic [23:0] A_STAT  = 24'h040008;
    localparam logic [23:0] A_GOOD  = 24'h04000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pkt = '0;
    logic        busy, done, pass;
    logic [1:0]  fail_code;
    logic [31:0] rx_good_count, m_writedata;
    logic [23:0] m_address;
    logic        m_read, m_write;
    logic [31:0] m_readdata = '0;
    logic        m_waitrequest = 1'b0;

    traffic_test_sequencer #(.POLL_GAP(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .pkt_count(pkt),
        .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
        .rx_good_count(rx_good_count), .m_address(m_address), .m_read(m_read),
        .m_write(m_write), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .m_waitrequest(m_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct { logic wr; logic [23:0] addr; logic [31:0] data; } txn_t;
    typedef struct { logic pass; logic [1:0] code; logic [31:0] rx; } verdict_t;

    txn_t     exp_q[$];
    verdict_t vq[$];
    int       checks = 0;
    int       errors = 0;

    // Scenario seen by the slave
    int          sc_waits = 0;
    int          sc_done_poll = 0;
    logic        sc_err = 1'b0;
    logic [31:0] sc_good = '0;
    logic        stat_any = 1'b0;
    logic        chk_gap = 1'b0;
    logic [31:0] exp_rx = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave: fixed wait states per access, scripted status/good-count data.
    int wcnt = 0;
    int poll_n = 0;
    always @(negedge clk) begin
        if (!busy) poll_n = 0;
        if (m_read || m_write) begin
            if (wcnt < sc_waits) begin
                m_waitrequest = 1'b1;
                wcnt++;
            end else begin
                m_waitrequest = 1'b0;
                wcnt = 0;
                if (m_read && m_address == A_STAT) begin
                    poll_n++;
                    m_readdata = (poll_n == sc_done_poll) ?
                                 (sc_err ? 32'h0000_000C : 32'h0000_0004) : 32'h0000_0010;
                end else if (m_read && m_address == A_GOOD) begin
                    m_readdata = sc_good;
                end else begin
                    m_readdata = 32'hDEAD_BEEF;
                end
            end
        end else begin
            m_waitrequest = 1'b0;
            wcnt = 0;
            m_readdata = $urandom;
        end
    end

    // Monitor: stall stability, completed accesses, verdicts.
    initial begin : monitor
        int cyc, cyc_ws;
        logic have_prev, first_rd_pend, done_prev, acc_prev;
        logic [23:0] p_addr;
        logic [1:0]  p_strb;
        logic [31:0] p_data;
        txn_t e;
        verdict_t v;
        cyc = 0; cyc_ws = 0; have_prev = 0; first_rd_pend = 0; done_prev = 0; acc_prev = 0;
        p_addr = '0; p_strb = '0; p_data = '0;
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (reset) begin
                have_prev = 0; first_rd_pend = 0; done_prev = 0; acc_prev = 0;
                continue;
            end
            if (m_read || m_write) begin
                chk("strobe_excl", {63'd0, m_read & m_write}, 64'd0);
                if (have_prev) begin
                    chk("stall_addr", {40'd0, m_address}, {40'd0, p_addr});
                    chk("stall_strobe", {62'd0, m_read, m_write}, {62'd0, p_strb});
                    if (m_write) chk("stall_wdata", {32'd0, m_writedata}, {32'd0, p_data});
                end
                if (m_read && first_rd_pend) begin
                    first_rd_pend = 0;
                    if (chk_gap) chk("first_poll_delay", 64'(cyc - cyc_ws), 64'(GAP + 1));
                end
                if (m_waitrequest) begin
                    have_prev = 1; p_addr = m_address; p_strb = {m_read, m_write}; p_data = m_writedata;
                end else begin
                    have_prev = 0;
                    if (m_read && stat_any && m_address == A_STAT) begin
                        // any number of status polls allowed in a timeout run
                    end else if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_txn actual wr=%0b addr=%06h required none", m_write, m_address);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txn_kind", {63'd0, m_write}, {63'd0, e.wr});
                        chk("txn_addr", {40'd0, m_address}, {40'd0, e.addr});
                        if (e.wr) chk("txn_wdata", {32'd0, m_writedata}, {32'd0, e.data});
                    end
                    if (m_write && m_address == A_START) begin
                        cyc_ws = cyc; first_rd_pend = 1;
                    end
                end
            end else begin
                have_prev = 0;
            end
            if (done && (!done_prev || acc_prev)) begin
                if (vq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done actual done=1 required none");
                end else begin
                    v = vq.pop_front();
                    chk("pass", {63'd0, pass}, {63'd0, v.pass});
                    chk("fail_code", {62'd0, fail_code}, {62'd0, v.code});
                    chk("rx_good_count", {32'd0, rx_good_count}, {32'd0, v.rx});
                    chk("busy_at_done", {63'd0, busy}, 64'd0);
                    chk("txns_left", 64'(exp_q.size()), 64'd0);
                    if (v.code == 2'd1)
                        chk("timeout_window", {63'd0, (cyc - cyc_ws >= int'(TMO)) && (cyc - cyc_ws <= int'(TMO + GAP + 3))}, 64'd1);
                end
            end
            acc_prev  = start && !busy;
            done_prev = done;
        end
    end

    // Reference model: expected bus transactions and verdict from the scenario.
    task automatic model(input logic [31:0] cnt, input int dpoll, input logic err, input logic [31:0] good);
        verdict_t v;
        if (cnt == 0) begin
            v = '{1'b1, 2'd0, exp_rx};
        end else begin
            exp_q.push_back('{1'b1, A_CTRL, 32'h1});
            exp_q.push_back('{1'b1, A_PKT, cnt});
            exp_q.push_back('{1'b1, A_START, 32'h1});
            if (dpoll == 0) begin
                v = '{1'b0, 2'd1, exp_rx};
            end else begin
                for (int i = 0; i < dpoll; i++) exp_q.push_back('{1'b0, A_STAT, 32'h0});
                if (err) begin
                    v = '{1'b0, 2'd2, exp_rx};
                end else begin
                    exp_q.push_back('{1'b0, A_GOOD, 32'h0});
                    exp_rx = good;
                    v = '{good == cnt, (good == cnt) ? 2'd0 : 2'd3, good};
                end
            end
        end
        vq.push_back(v);
    endtask

    task automatic pulse_start(input logic [31:0] cnt);
        @(negedge clk);
        start = 1'b1; pkt = cnt;
        @(negedge clk);
        start = 1'b0; pkt = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 5000) begin
            @(negedge clk); n++;
        end
        if (!done) begin
            errors++;
            $display("FAIL done_timeout actual done=0 required done=1");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic setup(input logic [31:0] cnt, input int waits, input int dpoll,
                         input logic err, input logic [31:0] good);
        sc_waits = waits; sc_done_poll = dpoll; sc_err = err; sc_good = good;
        stat_any = (dpoll == 0);
        model(cnt, dpoll, err, good);
    endtask

    task automatic run(input logic [31:0] cnt, input int waits, input int dpoll,
                       input logic err, input logic [31:0] good);
        setup(cnt, waits, dpoll, err, good);
        pulse_start(cnt);
        wait_done();
        stat_any = 1'b0;
    endtask

    initial begin : stim
        int n;
        logic [31:0] c, g;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_strobes", {62'd0, m_read, m_write}, 64'd0);
        chk("rst_rx", {32'd0, rx_good_count}, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Good run, zero wait, first-poll timing checked
        chk_gap = 1'b1;
        run(32'd100, 0, 5, 1'b0, 32'd100);
        chk_gap = 1'b0;
        // Stalls on every access
        run(32'd100, 3, 5, 1'b0, 32'd100);
        // Monitor error with done also set
        run(32'd100, 0, 2, 1'b1, 32'd100);
        // Timeout
        run(32'd100, 0, 0, 1'b0, 32'd0);
        // Count mismatch
        run(32'd100, 0, 3, 1'b0, 32'd99);
        // Zero count from DONE: done/pass one cycle after start
        setup(32'd0, 0, 1, 1'b0, 32'd0);
        pulse_start(32'd0);
        chk("zero_done", {63'd0, done}, 64'd1);
        chk("zero_pass", {63'd0, pass}, 64'd1);
        repeat (3) @(negedge clk);

        // Start while busy is ignored
        setup(32'd40, 1, 2, 1'b0, 32'd40);
        pulse_start(32'd40);
        repeat (8) @(negedge clk);
        chk("busy_mid", {63'd0, busy}, 64'd1);
        pulse_start(32'd7);
        wait_done();

        // Reset during a stalled status read
        setup(32'd55, 50, 3, 1'b0, 32'd55);
        pulse_start(32'd55);
        n = 0;
        while (!m_read && n < 2000) begin
            @(negedge clk); n++;
        end
        chk("reached_rd_stat", {63'd0, m_read}, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_strobes", {62'd0, m_read, m_write}, 64'd0);
        chk("rst_async_outs", {busy, done, pass, fail_code, rx_good_count, m_address}, 64'd0);
        chk("rst_async_wdata", {32'd0, m_writedata}, 64'd0);
        exp_q.delete(); vq.delete(); exp_rx = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run(32'd100, 0, 1, 1'b0, 32'd100);

        // Randomized runs
        for (int i = 0; i < 10; i++) begin
            c = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            g = ($urandom_range(0, 3) == 0) ? (c ^ (32'd1 << $urandom_range(0, 31))) : c;
            run(c, $urandom_range(0, 3), $urandom_range(1, 6), ($urandom_range(0, 3) == 0), g);
        end

        chk("verdicts_left", 64'(vq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
